// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the pipeline stages.
//   XLEN           - datapath width
//   NopInstr       - bubble encoding (addi x0,x0,0)
//   DefaultResetPc - PC loaded on reset; the program image starts at word 1
//   if_id_t        - IF/ID pipeline register contents
//   align_word()   - clears the two byte-offset bits of an address
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NopInstr       = 32'h0000_0013;
   localparam logic [XLEN-1:0] DefaultResetPc = 32'h0000_0004;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
   } if_id_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings.
//   imem_addr/imem_instr              - combinational instruction memory port
//   stall                             - hazard unit hold request
//   redirect_valid/redirect_target    - EX taken branch or jump
//   if_id_valid/pc/pc_plus4/instr     - IF/ID register towards decode
//   fetch_err                         - sticky misaligned-redirect flag
//   perf_*                            - event counters, only with FETCH_PERF_CNT_EN
// The master modport is the fetch stage; slave is the environment around it.
interface fetch_stage_if;
   import cpu_pkg::*;

   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_instr;
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            if_id_valid;
   logic [XLEN-1:0] if_id_pc;
   logic [XLEN-1:0] if_id_pc_plus4;
   logic [XLEN-1:0] if_id_instr;
   logic            fetch_err;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]     perf_fetched;
   logic [31:0]     perf_stalled;
   logic [31:0]     perf_flushed;
`endif

   modport master (
      output imem_addr,
      input  imem_instr,
      input  stall,
      input  redirect_valid,
      input  redirect_target,
      output if_id_valid,
      output if_id_pc,
      output if_id_pc_plus4,
      output if_id_instr,
`ifdef FETCH_PERF_CNT_EN
      output perf_fetched,
      output perf_stalled,
      output perf_flushed,
`endif
      output fetch_err
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output stall,
      output redirect_valid,
      output redirect_target,
      input  if_id_valid,
      input  if_id_pc,
      input  if_id_pc_plus4,
      input  if_id_instr,
`ifdef FETCH_PERF_CNT_EN
      input  perf_fetched,
      input  perf_stalled,
      input  perf_flushed,
`endif
      input  fetch_err
   );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID-style pipeline register with bubble/hold/load controls.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   bubble_i      - squash: valid=0, instr=NopVal, pc fields keep old values
//   hold_i        - keep current contents (lower priority than bubble)
//   load_i        - capture d_i (lowest priority)
//   d_i / q_o     - register input / output
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] NopVal = NopInstr
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   bubble_i,
   input  logic   hold_i,
   input  logic   load_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (bubble_i) begin
         q_d.valid = 1'b0;
         q_d.instr = NopVal;
      end else if (load_i && !hold_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q.valid    <= 1'b0;
         q_q.pc       <= '0;
         q_q.pc_plus4 <= '0;
         q_q.instr    <= NopVal;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline. Owns the PC, addresses the
// combinational instruction memory and captures the returned word into IF/ID.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - fetch_stage_if.master: memory port, stall, redirect, IF/ID outputs,
//            fetch_err and (with FETCH_PERF_CNT_EN) perf_fetched/stalled/flushed
// Per edge: redirect (bubble + load masked target) > stall (hold) > advance.
// Optional feature macro: FETCH_PERF_CNT_EN adds three wrapping 32-bit counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DefaultResetPc,
   parameter logic [XLEN-1:0] NOP_INSTR = NopInstr
) (
   input logic          clk,
   input logic          rst_n,
   fetch_stage_if.master bus
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic            err_q, err_d;
   if_id_t          fetch_d;
   if_id_t          if_id_q;

   assign pc_plus4      = pc_q + 32'd4;   // wraps modulo 2^32 by design
   assign bus.imem_addr = pc_q;

   always_comb begin
      pc_d  = pc_q;
      err_d = err_q;
      if (bus.redirect_valid) begin
         // Misaligned targets still load, with the byte offset dropped.
         pc_d = align_word(bus.redirect_target);
         if (bus.redirect_target[1:0] != 2'b00) begin
            err_d = 1'b1;
         end
      end else if (!bus.stall) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      fetch_d.valid    = 1'b1;
      fetch_d.pc       = pc_q;
      fetch_d.pc_plus4 = pc_plus4;
      fetch_d.instr    = bus.imem_instr;
   end

   if_id_reg #(
      .NopVal (NOP_INSTR)
   ) u_if_id (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .bubble_i (bus.redirect_valid),
      .hold_i   (bus.stall),
      .load_i   (1'b1),
      .d_i      (fetch_d),
      .q_o      (if_id_q)
   );

   assign bus.if_id_valid    = if_id_q.valid;
   assign bus.if_id_pc       = if_id_q.pc;
   assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
   assign bus.if_id_instr    = if_id_q.instr;
   assign bus.fetch_err      = err_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q, stalled_q, flushed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= '0;
         stalled_q <= '0;
         flushed_q <= '0;
      end else if (bus.redirect_valid) begin
         flushed_q <= flushed_q + 32'd1;
      end else if (bus.stall) begin
         stalled_q <= stalled_q + 32'd1;
      end else begin
         fetched_q <= fetched_q + 32'd1;
      end
   end

   assign bus.perf_fetched = fetched_q;
   assign bus.perf_stalled = stalled_q;
   assign bus.perf_flushed = flushed_q;
`endif

endmodule
